// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32x32 multiply / divide unit with HI/LO registers.
// Multiply uses shift-add, divide uses restoring shift-subtract, both on
// unsigned magnitudes over 32 iteration cycles, followed by a sign-fix cycle.
// MTHI/MTLO write HI/LO directly while idle.
//
// Ports:
//   clk    - clock, rising edge
//   rstn   - asynchronous active-low reset
//   start  - issue strobe, sampled only while busy=0
//   op     - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO
//   A, B   - rs / rt operands
//   busy   - iterative operation in flight (registered)
//   done   - one-cycle pulse when HI/LO take a mul/div result (registered)
//   hi, lo - architectural HI/LO registers
//
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO handled here
// CALC  | 32 iteration steps, counter 0..31
// FIX   | sign correction and HI/LO write, done pulse
module muldiv_unit (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic        is_div;
    logic        neg_q;     // product sign (mul) or quotient sign (div)
    logic        neg_r;     // remainder sign (div only)
    logic [31:0] opnd;      // multiplicand (mul) or divisor (div) magnitude
    logic [63:0] acc;       // {partial product} or {remainder, quotient}

    logic        signed_op;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] rem_sh;
    logic [32:0] div_diff;
    logic [63:0] div_next;
    logic [63:0] mul_res;
    logic [31:0] quo_res;
    logic [31:0] rem_res;

    assign signed_op = ~op[2] & ~op[0];
    assign abs_a     = (signed_op && A[31]) ? -A : A;
    assign abs_b     = (signed_op && B[31]) ? -B : B;

    // Multiplier sits in acc[31:0] and shifts out as the product shifts in.
    assign mul_sum   = {1'b0, acc[63:32]} + {1'b0, opnd};
    assign mul_next  = acc[0] ? {mul_sum, acc[31:1]} : {1'b0, acc[63:1]};

    // Dividend sits in acc[31:0]; quotient bits shift in from the bottom.
    assign rem_sh    = {acc[63:32], acc[31]};
    assign div_diff  = rem_sh - {1'b0, opnd};
    assign div_next  = div_diff[32] ? {rem_sh[31:0], acc[30:0], 1'b0}
                                    : {div_diff[31:0], acc[30:0], 1'b1};

    assign mul_res   = neg_q ? -acc : acc;
    assign quo_res   = neg_q ? -acc[31:0] : acc[31:0];
    assign rem_res   = neg_r ? -acc[63:32] : acc[63:32];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= IDLE;
            cnt    <= 5'd0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            opnd   <= 32'd0;
            acc    <= 64'd0;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= 32'd0;
            lo     <= 32'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        case (op)
                            3'b000, 3'b001, 3'b010, 3'b011: begin
                                is_div <= op[1];
                                opnd   <= op[1] ? abs_b : abs_a;
                                acc    <= {32'd0, op[1] ? abs_a : abs_b};
                                // Divide by zero leaves an all-ones quotient
                                // uncorrected; the remainder path already
                                // reproduces A.
                                neg_q  <= signed_op & (A[31] ^ B[31]) &
                                          ~(op[1] & (B == 32'd0));
                                neg_r  <= signed_op & A[31];
                                cnt    <= 5'd0;
                                busy   <= 1'b1;
                                state  <= CALC;
                            end
                            3'b100:  hi <= A;
                            3'b101:  lo <= A;
                            default: ;
                        endcase
                    end
                end
                CALC: begin
                    acc <= is_div ? div_next : mul_next;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (is_div) begin
                        hi <= rem_res;
                        lo <= quo_res;
                    end else begin
                        hi <= mul_res[63:32];
                        lo <= mul_res[31:0];
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total    = 0;

    // Bench-side copy of HI/LO, updated only from hand-computed values.
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    muldiv_unit dut (
        .clk   (clk),
        .rstn  (rstn),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Call from a point just after a falling edge; returns 1 time unit after
    // the accepting rising edge (E0) with start released.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Issues a mul/div op and follows it to done. Returns at the falling edge
    // of the done cycle, so an immediate second call issues at E34.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input string tag);
        int busy_cyc = 0;
        int done_at  = -1;
        bit stable   = 1'b1;
        issue(o, a, b);
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            if (busy) busy_cyc++;
            if (done) begin
                done_at = j;
                break;
            end
            if (hi !== m_hi || lo !== m_lo) stable = 1'b0;
        end
        check({tag, " done_edge"}, 64'(done_at), 64'd33);
        check({tag, " busy_cycles"}, 64'(busy_cyc), 64'd33);
        check({tag, " hilo_held"}, {63'd0, stable}, 64'd1);
        check({tag, " hi"}, {32'd0, hi}, {32'd0, exp_hi});
        check({tag, " lo"}, {32'd0, lo}, {32'd0, exp_lo});
        m_hi = exp_hi;
        m_lo = exp_lo;
    endtask

    initial begin
        bit seen;
        rstn  = 1'b0;
        start = 1'b0;
        op    = 3'b000;
        A     = 32'd0;
        B     = 32'd0;
        repeat (3) @(negedge clk);
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset done", {63'd0, done}, 64'd0);
        check("reset hilo", {hi, lo}, 64'd0);
        rstn = 1'b1;
        @(negedge clk);

        // MULT -3 * 5 = -15, plus single done pulse
        run_op(3'b000, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, "mult_neg");
        @(negedge clk);
        check("mult_neg done_single", {63'd0, done}, 64'd0);
        check("mult_neg busy_after", {63'd0, busy}, 64'd0);

        run_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max");
        @(negedge clk);
        run_op(3'b010, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg");
        @(negedge clk);
        run_op(3'b011, 32'd7, 32'd2, 32'd1, 32'd3, "divu");
        // back-to-back: second op issued on E34 of the first
        run_op(3'b011, 32'h1234, 32'd0, 32'h1234, 32'hFFFFFFFF, "divu_by0");
        @(negedge clk);
        run_op(3'b010, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, "div_by0_neg");
        @(negedge clk);
        run_op(3'b010, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, "div_ovf");
        @(negedge clk);
        run_op(3'b000, 32'h00012345, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFDB976, "mult_mixed");
        @(negedge clk);

        // MTHI while idle
        issue(3'b100, 32'hAAAA5555, 32'd0);
        @(negedge clk);
        check("mthi hi", {32'd0, hi}, 64'h00000000AAAA5555);
        check("mthi lo", {32'd0, lo}, {32'd0, m_lo});
        check("mthi busy", {63'd0, busy}, 64'd0);
        check("mthi done", {63'd0, done}, 64'd0);
        m_hi = 32'hAAAA5555;

        // MTLO while idle
        issue(3'b101, 32'h0F0F1234, 32'd0);
        @(negedge clk);
        check("mtlo lo", {32'd0, lo}, 64'h000000000F0F1234);
        m_lo = 32'h0F0F1234;

        // reserved op does nothing
        issue(3'b110, 32'h12345678, 32'h9);
        @(negedge clk);
        check("op110 hilo", {hi, lo}, {m_hi, m_lo});
        check("op110 busy", {63'd0, busy}, 64'd0);

        // MTLO while busy is ignored; in-flight result still lands
        issue(3'b001, 32'd3, 32'd4);
        repeat (5) @(negedge clk);
        issue(3'b101, 32'h0000DEAD, 32'd0);
        @(negedge clk);
        check("mtlo_busy lo_unchanged", {32'd0, lo}, {32'd0, m_lo});
        check("mtlo_busy busy", {63'd0, busy}, 64'd1);
        seen = 1'b0;
        for (int j = 0; j < 40; j++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("mtlo_busy done_seen", {63'd0, seen}, 64'd1);
        check("mtlo_busy result", {hi, lo}, 64'd12);
        m_hi = 32'd0;
        m_lo = 32'd12;
        @(negedge clk);

        // reset mid-operation
        issue(3'b000, 32'h00010000, 32'h00030000);
        repeat (9) @(negedge clk);
        rstn = 1'b0;
        #1;
        check("midreset busy", {63'd0, busy}, 64'd0);
        check("midreset done", {63'd0, done}, 64'd0);
        check("midreset hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        m_hi = 32'd0;
        m_lo = 32'd0;
        repeat (2) @(negedge clk);
        check("postreset hilo", {hi, lo}, 64'd0);
        run_op(3'b001, 32'd6, 32'd7, 32'd0, 32'd42, "multu_after_rst");

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
